// File: rtl/switch_pkg.sv
// Shared types and constants for the switch event/toggle block.
// LONG_PRESS_EN (when defined) enables long-press detection in each lane.
package switch_pkg;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StPress = 2'd1,
        StLong  = 2'd2
    } lane_state_e;

    localparam int unsigned LONG_CNT_DEF = 25000000;
    localparam int unsigned PressCntW    = 8;

    function automatic logic [PressCntW-1:0] popcount8(input logic [7:0] v);
        logic [PressCntW-1:0] n;
        n = '0;
        for (int i = 0; i < 8; i++) begin
            n = n + PressCntW'(v[i]);
        end
        return n;
    endfunction

endpackage

// File: rtl/switch_lane_fsm.sv
// One switch lane: press FSM, LED toggle register and one-cycle event pulses.
// LONG_PRESS_EN adds the hold counter and LONG state; otherwise every release toggles.
module switch_lane_fsm
    import switch_pkg::*;
`ifdef LONG_PRESS_EN
#(
    parameter int unsigned LONG_CNT = LONG_CNT_DEF
)
`endif
(
    input  logic clk_i,
    input  logic rst_ni,
    input  logic switch_i,
    output logic led_o,
    output logic release_o,
    output logic long_o,
    output logic rel_evt_o
);

    lane_state_e state_q;
    logic        led_q;
    logic        rel_q;

`ifdef LONG_PRESS_EN
    localparam int unsigned CntW = (LONG_CNT > 1) ? $clog2(LONG_CNT) : 1;
    localparam logic [CntW-1:0] CntMax = CntW'(LONG_CNT - 1);

    logic [CntW-1:0] cnt_q;
    logic            long_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            led_q   <= 1'b0;
            rel_q   <= 1'b0;
            long_q  <= 1'b0;
        end else begin
            rel_q  <= 1'b0;
            long_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (switch_i) begin
                        state_q <= StPress;
                        cnt_q   <= '0;
                    end
                end
                StPress: begin
                    if (!switch_i) begin
                        state_q <= StIdle;
                        led_q   <= ~led_q;
                        rel_q   <= 1'b1;
                    end else if (cnt_q == CntMax) begin
                        state_q <= StLong;
                        long_q  <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                // Counter stays frozen here; releasing is silent.
                StLong: begin
                    if (!switch_i) begin
                        state_q <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign long_o = long_q;
`else
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= StIdle;
            led_q   <= 1'b0;
            rel_q   <= 1'b0;
        end else begin
            rel_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (switch_i) begin
                        state_q <= StPress;
                    end
                end
                StPress: begin
                    if (!switch_i) begin
                        state_q <= StIdle;
                        led_q   <= ~led_q;
                        rel_q   <= 1'b1;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign long_o = 1'b0;
`endif

    assign led_o     = led_q;
    assign release_o = rel_q;
    // Same-edge release indication so the top's count moves with the LED.
    assign rel_evt_o = (state_q == StPress) && !switch_i;

endmodule

// File: rtl/switch_event_toggle.sv
// Top: NUM_SW independent switch lanes plus the shared short-press counter.
// LONG_PRESS_EN (when defined) enables long-press detection in the lanes.
module switch_event_toggle
    import switch_pkg::*;
#(
    parameter int unsigned NUM_SW   = 4,
    parameter int unsigned LONG_CNT = LONG_CNT_DEF
) (
    input  logic                 i_Clk,
    input  logic                 i_Rst_L,
    input  logic [NUM_SW-1:0]    i_Switch,
    output logic [NUM_SW-1:0]    o_LED,
    output logic [NUM_SW-1:0]    o_Release_Pulse,
    output logic [NUM_SW-1:0]    o_Long_Pulse,
    output logic [PressCntW-1:0] o_Press_Count
);

    if (NUM_SW < 1 || NUM_SW > 8) begin : g_bad_num_sw
        $error("switch_event_toggle: NUM_SW must be 1..8");
    end
    if (LONG_CNT < 2) begin : g_bad_long_cnt
        $error("switch_event_toggle: LONG_CNT must be at least 2");
    end

    logic [NUM_SW-1:0]    rel_evt;
    logic [PressCntW-1:0] cnt_q, cnt_d;

    for (genvar g = 0; g < NUM_SW; g++) begin : g_lane
        switch_lane_fsm
`ifdef LONG_PRESS_EN
        #(
            .LONG_CNT (LONG_CNT)
        )
`endif
        u_lane (
            .clk_i     (i_Clk),
            .rst_ni    (i_Rst_L),
            .switch_i  (i_Switch[g]),
            .led_o     (o_LED[g]),
            .release_o (o_Release_Pulse[g]),
            .long_o    (o_Long_Pulse[g]),
            .rel_evt_o (rel_evt[g])
        );
    end

    // Modulo-256 accumulation; wrap is intended.
    always_comb begin
        cnt_d = cnt_q + popcount8(8'(rel_evt));
    end

    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign o_Press_Count = cnt_q;

endmodule

// File: doc/switch_event_toggle.md
SWITCH_EVENT_TOGGLE -- requirements
Module: switch_event_toggle

Interface
REQ-001 Parameter NUM_SW, default 4: number of independent switch lanes, range 1..8.
REQ-002 Parameter LONG_CNT, default 25000000: held cycles that make a long press (1 s at 25 MHz), minimum 2.
REQ-003 i_Clk  input  1  single system clock; all state changes on its rising edge.
REQ-004 i_Rst_L  input  1  reset, asynchronous, active-low.
REQ-005 i_Switch  input  NUM_SW  debounced switch levels, 1 = pressed; already synchronous to i_Clk.
REQ-006 o_LED  output  NUM_SW  per-lane toggle state, 1 = LED on.
REQ-007 o_Release_Pulse  output  NUM_SW  one-cycle pulse per lane on a short-press release.
REQ-008 o_Long_Pulse  output  NUM_SW  one-cycle pulse per lane when a hold reaches LONG_CNT.
REQ-009 o_Press_Count  output  8  running total of short presses across all lanes.

Function
REQ-010 Each lane shall run an independent FSM with states IDLE, PRESS and LONG.
REQ-011 IDLE: sampled i_Switch=1 -> PRESS, hold counter cleared to 0; otherwise stay.
REQ-012 PRESS with i_Switch=1: hold counter increments by 1 per cycle; on the edge where counter equals LONG_CNT-1 -> LONG and o_Long_Pulse high for the following cycle.
REQ-013 PRESS with i_Switch=0: -> IDLE, o_LED lane inverted, o_Release_Pulse high for exactly the following cycle.
REQ-014 LONG with i_Switch=1: stay, counter frozen, no further long pulses.
REQ-015 LONG with i_Switch=0: -> IDLE with no LED toggle, no release pulse and no count increment.
REQ-016 Latency from the sampling edge to o_LED/o_Release_Pulse/o_Long_Pulse change shall be 1 edge; all outputs are registered.
REQ-017 A press of one cycle (1 then 0) shall count as a short press.
REQ-018 o_Press_Count shall add the number of lanes releasing a short press in that cycle (0..NUM_SW), modulo 256.
REQ-019 o_Press_Count wrap-around: 255 + 1 = 0, 254 + 3 = 1; no saturation and no overflow flag.
REQ-020 Hold counter width shall be clog2(LONG_CNT) bits; it never exceeds LONG_CNT-1.

Reset
REQ-021 i_Rst_L=0 shall immediately force all lanes to IDLE and o_LED, o_Release_Pulse, o_Long_Pulse, o_Press_Count and hold counters to 0.
REQ-022 Reset asserted mid-press shall discard the press: no toggle, pulse or count.
REQ-023 A switch held across reset deassertion shall be treated as a new press starting at the first edge after deassertion.

Configuration
REQ-024 Macro LONG_PRESS_EN defined: long-press detection per REQ-012/014/015 is present.
REQ-025 LONG_PRESS_EN undefined: no LONG state or hold counters; every release toggles and counts; o_Long_Pulse tied to 0; LONG_CNT ignored.

Structure
REQ-026 Shared package switch_pkg shall hold the lane-state typedef (IDLE/PRESS/LONG), the LONG_CNT default constant and the press-count width constant (8).
REQ-027 Per-lane FSM, hold counter, LED register and pulses shall live in sub-module switch_lane_fsm, instantiated NUM_SW times by generate.
REQ-028 The top shall hold only the popcount adder and o_Press_Count register.

Verification (LONG_CNT=8, NUM_SW=4)
REQ-029 Lane 0 held 3 cycles then released -> o_LED=0001, o_Release_Pulse[0] one cycle, o_Press_Count=1.
REQ-030 Lane 1 held 12 cycles -> o_Long_Pulse[1] exactly once, 8 cycles after press; release -> o_LED[1]=0, count unchanged.
REQ-031 Lanes 0-3 released on the same edge after short holds -> o_Release_Pulse=1111, o_Press_Count += 4.
REQ-032 Preload count to 254 via 254 short presses, then 3 simultaneous releases -> o_Press_Count=1.
REQ-033 i_Rst_L low during lane 2 hold of 5 cycles -> outputs 0 immediately; switch held through deassertion then released -> o_LED[2]=1, count=1.
REQ-034 Build without LONG_PRESS_EN, lane 3 held 20 cycles then released -> o_Long_Pulse stays 0, o_LED[3]=1, count=1.
